// File: rtl/hex_pkg.sv
// Shared types and constants for the hex display scheduler.
//   hex_sched_state_t : scheduler FSM states
//   HEX_BLANK         : active-low segment pattern with every segment off
//   HEX_DIGIT_W       : bits per displayed digit (dp + 7 segments)
//   NIBBLE_W          : bits per hex input digit
package hex_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } hex_sched_state_t;

  localparam logic [6:0] HEX_BLANK   = 7'h7F;
  localparam int         HEX_DIGIT_W = 8;
  localparam int         NIBBLE_W    = 4;

endpackage

// File: rtl/Hex_Driver.sv
// Hex nibble to seven-segment decoder (active-low segments).
//   In0  : 4-bit hex value
//   Out0 : segments g..a, active-low (bit 0 = a, bit 6 = g)
module Hex_Driver (
  input  logic [3:0] In0,
  output logic [6:0] Out0
);

  always_comb begin
    Out0 = 7'h7F;
    unique case (In0)
      4'h0: Out0 = 7'h40;
      4'h1: Out0 = 7'h79;
      4'h2: Out0 = 7'h24;
      4'h3: Out0 = 7'h30;
      4'h4: Out0 = 7'h19;
      4'h5: Out0 = 7'h12;
      4'h6: Out0 = 7'h02;
      4'h7: Out0 = 7'h78;
      4'h8: Out0 = 7'h00;
      4'h9: Out0 = 7'h10;
      4'hA: Out0 = 7'h08;
      4'hB: Out0 = 7'h03;
      4'hC: Out0 = 7'h46;
      4'hD: Out0 = 7'h21;
      4'hE: Out0 = 7'h06;
      4'hF: Out0 = 7'h0E;
      default: Out0 = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Sequences a multi-digit hex value through one shared Hex_Driver, one digit
// per clock, then commits every decoded digit to the display in a single cycle.
// Supports leading-zero blanking (captured with the load) and a live blink
// enable.
//   Clk, Reset  : system clock, synchronous active-high reset
//   load_valid  : producer offers load_data/load_dp/blank_lz
//   load_ready  : high while IDLE; a value is accepted when both are high
//   load_data   : hex nibbles, digit i at [4i+3:4i]
//   load_dp     : per-digit decimal point enable, active-high
//   blank_lz    : leading-zero blanking enable, sampled with the load
//   blink_en    : live blink enable, applied combinationally at the output
//   busy        : high while a value is being scanned or committed
//   hex_out     : active-low segments, digit i at [8i+7:8i], bit 7 = dp
module hex_display_scheduler
  import hex_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0]  load_data,
  input  logic [NUM_DIGITS-1:0]           load_dp,
  input  logic                            blank_lz,
  input  logic                            blink_en,
  output logic                            busy,
  output logic [HEX_DIGIT_W*NUM_DIGITS-1:0] hex_out
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  hex_sched_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             lead_q, lead_d;
  logic [NIBBLE_W*NUM_DIGITS-1:0] data_q, data_d;
  logic [NUM_DIGITS-1:0]          dp_q, dp_d;
  logic                           blz_q, blz_d;
  logic [HEX_DIGIT_W-1:0] shadow_q [NUM_DIGITS];
  logic [HEX_DIGIT_W-1:0] shadow_d [NUM_DIGITS];
  logic [HEX_DIGIT_W-1:0] disp_q   [NUM_DIGITS];
  logic [HEX_DIGIT_W-1:0] disp_d   [NUM_DIGITS];
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   phase_q, phase_d;

  logic [NIBBLE_W-1:0] nib;
  logic [6:0]          seg;
  logic                blank_digit;

  assign nib = data_q[idx_q*NIBBLE_W +: NIBBLE_W];

  // Single decoder shared across all digits, steered by idx.
  Hex_Driver u_hex_driver (
    .In0  (nib),
    .Out0 (seg)
  );

  // Digit 0 always shows, so an all-zero value still displays "0".
  assign blank_digit = blz_q && lead_q && (nib == '0) && (idx_q != '0);

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == SCAN) || (state_q == COMMIT);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lead_d   = lead_q;
    data_d   = data_q;
    dp_d     = dp_q;
    blz_d    = blz_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;

    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          data_d  = load_data;
          dp_d    = load_dp;
          blz_d   = blank_lz;
          idx_d   = IDX_W'(NUM_DIGITS - 1);
          lead_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        shadow_d[idx_q] = blank_digit ? {~dp_q[idx_q], HEX_BLANK}
                                      : {~dp_q[idx_q], seg};
        if (nib != '0) lead_d = 1'b0;
        if (idx_q == '0) state_d = COMMIT;
        else             idx_d   = idx_q - 1'b1;
      end
      COMMIT: begin
        // Whole-value swap keeps the outputs free of half-updated values.
        disp_d  = shadow_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running blink timebase, independent of the scheduler state.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lead_q  <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) disp_q[i] <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lead_q  <= lead_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      disp_q  <= disp_d;
    end
  end

  always_ff @(posedge Clk) begin
    data_q   <= data_d;
    dp_q     <= dp_d;
    blz_q    <= blz_d;
    shadow_q <= shadow_d;
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) hex_out[i*HEX_DIGIT_W +: HEX_DIGIT_W] = disp_q[i];
    if (blink_en && phase_q) hex_out = '1;
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
module tb_hex_display_scheduler;

  localparam logic [47:0] ONES    = {48{1'b1}};
  localparam logic [47:0] V123456 = 48'hF9A4B0999282;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [23:0] load_data = '0;
  logic [5:0]  load_dp = '0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic        busy;
  logic [47:0] hex_out;

  int checks = 0;
  int failures = 0;
  logic [47:0] shown = ONES;

  // Reference blink timebase: half-period of 4 cycles, restarted by reset.
  int   mcnt = 0;
  logic mph  = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      mcnt <= 0;
      mph  <= 1'b0;
    end else if (mcnt == 3) begin
      mcnt <= 0;
      mph  <= ~mph;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  hex_display_scheduler #(
    .NUM_DIGITS (6),
    .BLINK_DIV  (4)
  ) dut (
    .Clk        (clk),
    .Reset      (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .busy       (busy),
    .hex_out    (hex_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (hex_out !== ONES || load_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: hex=%h ready=%b busy=%b, required hex=%h ready=1 busy=0",
               hex_out, load_ready, busy, ONES);
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (hex_out !== ONES || load_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: hex=%h ready=%b busy=%b, required hex=%h ready=1 busy=0",
               hex_out, load_ready, busy, ONES);
    end
  endtask

  // Accept at edge 0; SCAN after edges 0..5, COMMIT after edge 6, new value after edge 7.
  task automatic run_load(input logic [23:0] d, input logic [5:0] dp, input logic blz,
                          input logic [47:0] exp, input string name);
    load_valid = 1'b1;
    load_data  = d;
    load_dp    = dp;
    blank_lz   = blz;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      checks++;
      if (busy !== 1'b1 || load_ready !== 1'b0 || hex_out !== shown) begin
        failures++;
        $display("FAIL %s_busy%0d: busy=%b ready=%b hex=%h, required busy=1 ready=0 hex=%h",
                 name, k, busy, load_ready, hex_out, shown);
      end
    end
    tick();
    checks++;
    if (hex_out !== exp || load_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_commit: hex=%h ready=%b busy=%b, required hex=%h ready=1 busy=0",
               name, hex_out, load_ready, busy, exp);
    end
    shown = exp;
  endtask

  task automatic test_basic();
    run_load(24'h123456, 6'b000000, 1'b0, V123456, "basic");
  endtask

  task automatic test_leading_zero();
    run_load(24'h00000A, 6'b000000, 1'b1, 48'hFFFFFFFFFF88, "lz_a");
    run_load(24'h000000, 6'b000001, 1'b1, 48'hFFFFFFFFFF40, "lz_zero_dp");
    run_load(24'h100200, 6'b000000, 1'b1, 48'hF9C0C0A4C0C0, "lz_interior");
    run_load(24'h000000, 6'b100000, 1'b0, 48'h40C0C0C0C0C0, "nolz_dp5");
  endtask

  task automatic test_ignore_while_busy();
    load_valid = 1'b1;
    load_data  = 24'h123456;
    load_dp    = '0;
    blank_lz   = 1'b0;
    tick();                       // edge 0: accepted
    load_valid = 1'b0;
    tick();                       // edge 1
    load_valid = 1'b1;
    load_data  = 24'hFFFFFF;
    tick();                       // edge 2
    tick();                       // edge 3
    load_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || hex_out !== shown) begin
      failures++;
      $display("FAIL ignore_midscan: busy=%b hex=%h, required busy=1 hex=%h", busy, hex_out, shown);
    end
    repeat (4) tick();            // edges 4..7
    checks++;
    if (hex_out !== V123456 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL ignore_commit: hex=%h ready=%b, required hex=%h ready=1",
               hex_out, load_ready, V123456);
    end
    repeat (9) tick();
    checks++;
    if (hex_out !== V123456 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_not_queued: hex=%h busy=%b, required hex=%h busy=0",
               hex_out, busy, V123456);
    end
    shown = V123456;
  endtask

  task automatic test_reset_mid_scan();
    load_valid = 1'b1;
    load_data  = 24'h00000A;
    load_dp    = '0;
    blank_lz   = 1'b0;
    tick();                       // edge 0: accepted
    load_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (hex_out !== ONES || load_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_scan: hex=%h ready=%b busy=%b, required hex=%h ready=1 busy=0",
               hex_out, load_ready, busy, ONES);
    end
    rst = 1'b0;
    shown = ONES;
    repeat (8) tick();
    checks++;
    if (hex_out !== ONES || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_aborted: hex=%h busy=%b, required hex=%h busy=0", hex_out, busy, ONES);
    end
  endtask

  task automatic test_blink();
    logic [47:0] exp;
    int on_cnt;
    int off_cnt;
    on_cnt  = 0;
    off_cnt = 0;
    run_load(24'h123456, 6'b000000, 1'b0, V123456, "blink_load");
    blink_en = 1'b1;
    #1;
    exp = mph ? ONES : V123456;
    checks++;
    if (hex_out !== exp) begin
      failures++;
      $display("FAIL blink_enable: hex=%h, required %h", hex_out, exp);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      exp = mph ? ONES : V123456;
      if (mph) off_cnt++;
      else     on_cnt++;
      checks++;
      if (hex_out !== exp) begin
        failures++;
        $display("FAIL blink_cycle%0d: hex=%h, required %h", k, hex_out, exp);
      end
    end
    checks++;
    if (on_cnt != 8 || off_cnt != 8) begin
      failures++;
      $display("FAIL blink_duty: on=%0d off=%0d, required on=8 off=8", on_cnt, off_cnt);
    end
    // Park in the blanked phase, then drop blink_en without a clock edge.
    for (int k = 0; k < 8 && !mph; k++) tick();
    blink_en = 1'b0;
    #1;
    checks++;
    if (hex_out !== V123456) begin
      failures++;
      $display("FAIL blink_off: hex=%h, required %h", hex_out, V123456);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leading_zero();
    test_ignore_while_busy();
    test_reset_mid_scan();
    test_blink();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_scheduler.md
# hex_display_scheduler

Sequencing controller for the board's six seven-segment displays. It accepts a 24-bit display value through a valid/ready handshake and walks it through a single shared `Hex_Driver` decoder, one digit per clock. It then commits all decoded digits atomically to the display outputs, with optional leading-zero blanking and blinking. It sits between any value producer (bus monitor, debug register, test logic) and the HEX pins.

## Interface
Parameters:
- `NUM_DIGITS`, 6: number of displays driven; digit 0 is least significant.
- `BLINK_DIV`, 25_000_000: clock cycles per blink half-period; must be ≥ 2.

Ports:
- `Clk` in 1: single system clock; all state changes on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `load_valid` in 1: producer presents a new value.
- `load_ready` out 1: block can accept a value; equals (state == IDLE).
- `load_data` in 4*NUM_DIGITS: hex nibbles; digit i is [4i+3:4i].
- `load_dp` in NUM_DIGITS: decimal point enable per digit, active-high.
- `blank_lz` in 1: leading-zero blanking enable, sampled with the load.
- `blink_en` in 1: live (unsampled) blink enable.
- `busy` out 1: high in SCAN or COMMIT.
- `hex_out` out 8*NUM_DIGITS: active-low segments; digit i is [8i+7:8i], bit 7 = dp, [6:0] = g..a.

## Operation
- States: IDLE, SCAN, COMMIT.
- IDLE: when `load_valid && load_ready`, capture `load_data`, `load_dp`, `blank_lz`. Set `idx` = NUM_DIGITS-1 and `lead` = 1, then go to SCAN. Without a handshake, stay in IDLE.
- SCAN: drive nibble[idx] and dp[idx] into the shared `Hex_Driver` and write its output into shadow[idx].
  - Blank the digit when blank_lz && lead && nibble==0 && idx!=0. A blanked digit writes shadow[idx] = {~dp[idx], 7'h7F}.
  - Clear `lead` on the first nonzero nibble.
  - Digit 0 is never blanked.
  - When idx==0, go to COMMIT; otherwise decrement idx.
- COMMIT: copy all shadow digits to the display register in one cycle, then go to IDLE.
- Outputs never show a partially updated value.
- `hex_out`:
  - Equals 8*NUM_DIGITS'1s (all off) when `blink_en && phase`.
  - Otherwise equals the display register.
- Blink: a counter of width $clog2(BLINK_DIV) counts 0..BLINK_DIV-1. `phase` toggles on wrap. The counter runs free regardless of state.
- `load_valid` while busy is ignored (not queued); the producer must hold until `load_ready`.
- Reset mid-SCAN or mid-COMMIT aborts the update.

## Timing
- Reset values:
  - State is IDLE, so `load_ready`=1 and `busy`=0.
  - Display register is all 1s, so `hex_out` is all 1s (blank).
  - Blink counter = 0 and `phase` = 0.
  - Shadow contents are don't-care.
- Handshake at edge 0 gives SCAN for edges 1..NUM_DIGITS and COMMIT at edge NUM_DIGITS+1.
- `hex_out` shows the new value after edge NUM_DIGITS+1, i.e. NUM_DIGITS+2 cycles after the accept cycle (8 for the default).
- `load_ready` returns high in the same cycle `hex_out` updates.
- Back-to-back loads: accept rate is one per NUM_DIGITS+2 cycles.
- Blink half-period is exactly BLINK_DIV cycles. `blink_en` takes effect combinationally with no added latency.

## Structure
- Package `hex_pkg` holds:
  - state enum `hex_sched_state_t` {IDLE, SCAN, COMMIT};
  - `HEX_BLANK` = 7'h7F;
  - `HEX_DIGIT_W` = 8, `NIBBLE_W` = 4.
- One sub-module instance: the existing `Hex_Driver`, instantiated exactly once and shared across digits by `idx`.
- Shadow and display registers are arrays of NUM_DIGITS × 8 bits.

## Test plan
- Reset, then idle 3 cycles → `hex_out`=48'hFFFFFFFFFFFF, `load_ready`=1, `busy`=0.
- Load 24'h123456, dp=0, blank_lz=0 → exactly 8 cycles after accept, `hex_out`=48'hF9A4B0999282. Before that it stays all 1s and `busy`=1 for 7 cycles.
- Load 24'h00000A, blank_lz=1 → `hex_out`=48'hFFFFFFFFFF88. Then load 24'h000000, blank_lz=1, dp=6'b000001 → 48'hFFFFFFFFFF40.
- Load 24'h100200, blank_lz=1 → interior zeros kept, `hex_out`=48'hF9C0C0A4C0C0.
- Pulse `load_valid` during SCAN with 24'hFFFFFF → ignored, first value committed. Assert `Reset` on scan cycle 3 → `hex_out` all 1s next cycle and `load_ready`=1.
- With BLINK_DIV=4, `blink_en`=1 and 24'h123456 loaded → `hex_out` alternates between 48'hF9A4B0999282 and all 1s every 4 cycles. Drop `blink_en` → value shown immediately.
